// File: rtl/spdif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spdif_pkg
// Brief    : Shared S/PDIF frame geometry, preamble patterns, channel-status map
// Revision : 1.0
// ============================================================================
package spdif_pkg;

    localparam int HALFCELLS_PER_FRAME = 128;
    localparam int FRAMES_PER_BLOCK    = 192;

    localparam logic [6:0] HC_LAST = 7'(HALFCELLS_PER_FRAME - 1);
    localparam logic [7:0] FR_LAST = 8'(FRAMES_PER_BLOCK - 1);

    // Transmitted MSB first, relative to a preceding line level of 0
    localparam logic [7:0] PREAMBLE_B = 8'b1110_1000;
    localparam logic [7:0] PREAMBLE_M = 8'b1110_0010;
    localparam logic [7:0] PREAMBLE_W = 8'b1110_0100;

    localparam logic [7:0] CS_BIT_COPY  = 8'd2;
    localparam logic [7:0] CS_BIT_RATE  = 8'd24;
    localparam logic [7:0] CS_BIT_FIXED = 8'd32;

    localparam logic [4:0] SLOT_DATA_FIRST = 5'd4;
    localparam logic [4:0] SLOT_V          = 5'd28;
    localparam logic [4:0] SLOT_U          = 5'd29;
    localparam logic [4:0] SLOT_C          = 5'd30;
    localparam logic [4:0] SLOT_P          = 5'd31;

    typedef enum logic [1:0] {
        PRE_B = 2'd0,
        PRE_M = 2'd1,
        PRE_W = 2'd2
    } preamble_e;

    typedef struct packed {
        logic [23:0] left;
        logic [23:0] right;
        logic        v;
    } hold_t;

    function automatic logic [7:0] preamble_pattern(input preamble_e kind);
        logic [7:0] pat;
        case (kind)
            PRE_B:   pat = PREAMBLE_B;
            PRE_M:   pat = PREAMBLE_M;
            default: pat = PREAMBLE_W;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spdif_cs_rom.sv
`default_nettype none
// ============================================================================
// Module   : spdif_cs_rom
// Brief    : Channel-status bit lookup for one frame of the 192-frame block
// Revision : 1.0
// ============================================================================
module spdif_cs_rom
    import spdif_pkg::*;
(
    input  logic [7:0] frame_idx_i,
    input  logic [3:0] rate_code_i,
    input  logic       copy_permit_i,
    output logic       c_bit_o
);

    always_comb begin
        c_bit_o = 1'b0;
        if (frame_idx_i == CS_BIT_COPY) begin
            c_bit_o = copy_permit_i;
        end else if (frame_idx_i >= CS_BIT_RATE && frame_idx_i < CS_BIT_RATE + 8'd4) begin
            // Rate field starts on a multiple of 4, so the low bits index the code
            c_bit_o = rate_code_i[frame_idx_i[1:0]];
        end else if (frame_idx_i == CS_BIT_FIXED) begin
            c_bit_o = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spdif_frame_encoder.sv
`default_nettype none
// ============================================================================
// Module   : spdif_frame_encoder
// Brief    : 24-bit stereo S/PDIF frame builder with biphase-mark line coding
// Revision : 1.0
// ============================================================================
module spdif_frame_encoder
    import spdif_pkg::*;
#(
    parameter logic CS_COPY_PERMIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] sample_left,
    input  logic [23:0] sample_right,
    input  logic        sample_valid,
    input  logic        validity,
    input  logic [3:0]  sample_rate_code,
    output logic        sample_ready,
    output logic        spdif_out,
    output logic        block_start,
    output logic        underrun
);

    logic [6:0] hc_q,   hc_d;
    logic [7:0] fr_q,   fr_d;
    logic       out_q,  out_d;
    logic       pol_q,  pol_d;
    logic       bs_q,   bs_d;
    logic       und_q,  und_d;
    logic [3:0] rate_q, rate_d;
    hold_t      hold_q, hold_d;

    logic        w_last_hc;
    logic        w_last_fr;
    logic [4:0]  w_slot;
    logic [4:0]  w_data_idx;
    logic [23:0] w_word;
    logic        w_c_bit;
    logic        w_parity;
    logic        w_bit;
    logic        w_in_pre;
    logic [2:0]  w_pre_idx;
    preamble_e   w_pre_kind;
    logic [7:0]  w_pattern;
    logic        w_pol;

    spdif_cs_rom u_cs_rom (
        .frame_idx_i   (fr_q),
        .rate_code_i   (rate_q),
        .copy_permit_i (CS_COPY_PERMIT),
        .c_bit_o       (w_c_bit)
    );

    assign w_last_hc    = (hc_q == HC_LAST);
    assign w_last_fr    = (fr_q == FR_LAST);
    assign sample_ready = rst_n & w_last_hc;

    assign spdif_out   = out_q;
    assign block_start = bs_q;
    assign underrun    = und_q;

    // Payload bit carried by the current slot
    always_comb begin
        w_slot     = hc_q[5:1];
        w_data_idx = w_slot - SLOT_DATA_FIRST;
        w_word     = hc_q[6] ? hold_q.right : hold_q.left;
        w_parity   = ^{w_c_bit, 1'b0, hold_q.v, w_word};
        if (w_slot == SLOT_P) begin
            w_bit = w_parity;
        end else if (w_slot == SLOT_C) begin
            w_bit = w_c_bit;
        end else if (w_slot == SLOT_U) begin
            w_bit = 1'b0;
        end else if (w_slot == SLOT_V) begin
            w_bit = hold_q.v;
        end else begin
            w_bit = w_word[w_data_idx];
        end
    end

    // Line level for the half-cell addressed by hc_q; registered into out_q
    always_comb begin
        w_in_pre  = (hc_q[5:3] == 3'd0);
        w_pre_idx = hc_q[2:0];
        if (hc_q[6]) begin
            w_pre_kind = PRE_W;
        end else if (fr_q == 8'd0) begin
            w_pre_kind = PRE_B;
        end else begin
            w_pre_kind = PRE_M;
        end
        w_pattern = preamble_pattern(w_pre_kind);
        // The whole preamble is inverted by the level held just before it starts
        w_pol = (w_pre_idx == 3'd0) ? out_q : pol_q;
        pol_d = w_in_pre ? w_pol : pol_q;

        if (w_in_pre) begin
            out_d = w_pattern[3'd7 - w_pre_idx] ^ w_pol;
        end else if (!hc_q[0] || w_bit) begin
            out_d = ~out_q;
        end else begin
            out_d = out_q;
        end
    end

    always_comb begin
        hc_d   = hc_q + 7'd1;
        fr_d   = fr_q;
        rate_d = rate_q;
        hold_d = hold_q;
        bs_d   = (hc_q == 7'd0) && (fr_q == 8'd0);
        und_d  = w_last_hc && !sample_valid;
        if (w_last_hc) begin
            fr_d = w_last_fr ? 8'd0 : fr_q + 8'd1;
            if (w_last_fr) begin
                rate_d = sample_rate_code;
            end
            if (sample_valid) begin
                hold_d.left  = sample_left;
                hold_d.right = sample_right;
                hold_d.v     = ~validity;
            end else begin
                hold_d.left  = 24'd0;
                hold_d.right = 24'd0;
                hold_d.v     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hc_q         <= 7'd0;
            fr_q         <= 8'd0;
            out_q        <= 1'b0;
            pol_q        <= 1'b0;
            bs_q         <= 1'b0;
            und_q        <= 1'b0;
            rate_q       <= 4'd0;
            hold_q.left  <= 24'd0;
            hold_q.right <= 24'd0;
            hold_q.v     <= 1'b1;
        end else begin
            hc_q   <= hc_d;
            fr_q   <= fr_d;
            out_q  <= out_d;
            pol_q  <= pol_d;
            bs_q   <= bs_d;
            und_q  <= und_d;
            rate_q <= rate_d;
            hold_q <= hold_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spdif_frame_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spdif_frame_encoder
// Brief    : Scoreboard bench: random sample pairs vs. a frame-level line decoder
// Revision : 1.0
// ============================================================================
module tb_spdif_frame_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] sample_left, sample_right;
    logic        sample_valid, validity;
    logic [3:0]  sample_rate_code;
    logic        sample_ready, spdif_out, block_start, underrun;

    always #5 clk = ~clk;

    spdif_frame_encoder #(.CS_COPY_PERMIT(1'b1)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_left      (sample_left),
        .sample_right     (sample_right),
        .sample_valid     (sample_valid),
        .validity         (validity),
        .sample_rate_code (sample_rate_code),
        .sample_ready     (sample_ready),
        .spdif_out        (spdif_out),
        .block_start      (block_start),
        .underrun         (underrun)
    );

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        v;
        int          fr;
        logic [3:0]  code;
    } exp_t;

    exp_t       exp_q[$];
    bit         und_q[$];
    int         tests = 0;
    int         fails = 0;
    int         edges = -1;
    logic [3:0] model_code;

    localparam logic [7:0] PAT_B = 8'b1110_1000;
    localparam logic [7:0] PAT_M = 8'b1110_0010;
    localparam logic [7:0] PAT_W = 8'b1110_0100;

    // Edges since reset release; cell k of the line stream is visible after edge k
    always @(posedge clk) begin
        if (!rst_n) edges <= 0;
        else if (edges >= 0) edges <= edges + 1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic cs_bit(input int fr, input logic [3:0] code);
        if (fr == 2) return 1'b1;
        if (fr >= 24 && fr <= 27) return code[fr - 24];
        return (fr == 32);
    endfunction

    // Slots 4..31 as a word: data LSB first, V, U, C, then even parity
    function automatic logic [27:0] sub_word(input logic [23:0] d, input logic v, input logic c);
        logic [26:0] body;
        body = {c, 1'b0, v, d};
        return {^body, body};
    endfunction

    // ------------------------------------------------------------------ monitor
    logic [127:0] cells, bs_v, un_v;
    logic         lvl_a, prev_lvl;
    int           mk, mc;

    task automatic check_frame(input int n);
        exp_t        e;
        bit          u;
        int          base, viol;
        logic        lvl;
        logic [7:0]  pre, exp_pre;
        logic [27:0] word;
        if (exp_q.size() == 0 || und_q.size() == 0) begin
            check($sformatf("scoreboard_empty_f%0d", n), 128'd1, 128'd0);
            return;
        end
        e = exp_q.pop_front();
        u = und_q.pop_front();
        viol = 0;
        for (int s = 0; s < 2; s++) begin
            base = s * 64;
            lvl  = (s == 1) ? cells[63] : lvl_a;
            for (int i = 0; i < 8; i++) pre[7 - i] = cells[base + i] ^ lvl;
            exp_pre = (s == 1) ? PAT_W : ((e.fr == 0) ? PAT_B : PAT_M);
            check($sformatf("preamble_f%0d_s%0d", n, s), 128'(pre), 128'(exp_pre));
            for (int j = 4; j < 32; j++) begin
                if (cells[base + 2*j] == cells[base + 2*j - 1]) viol++;
                word[j - 4] = cells[base + 2*j] ^ cells[base + 2*j + 1];
            end
            check($sformatf("subframe_f%0d_s%0d", n, s), 128'(word),
                  128'(sub_word((s == 1) ? e.r : e.l, e.v, cs_bit(e.fr, e.code))));
        end
        check($sformatf("bmc_violations_f%0d", n), 128'(viol), 128'd0);
        check($sformatf("block_start_f%0d", n), bs_v, (e.fr == 0) ? 128'd1 : 128'd0);
        check($sformatf("underrun_f%0d", n), un_v, u ? (128'd1 << 127) : 128'd0);
    endtask

    always @(negedge clk) begin
        if (edges == 0) begin
            check("reset_spdif_out", 128'(spdif_out), 128'd0);
            check("reset_block_start", 128'(block_start), 128'd0);
            check("reset_underrun", 128'(underrun), 128'd0);
            prev_lvl = 1'b0;
        end else if (edges > 0) begin
            mk = edges - 1;
            mc = mk % 128;
            if (mc == 0) lvl_a = prev_lvl;
            cells[mc] = spdif_out;
            bs_v[mc]  = block_start;
            un_v[mc]  = underrun;
            prev_lvl  = spdif_out;
            if (mc == 127) check_frame(mk / 128);
        end
    end

    // ------------------------------------------------------------------ stimulus
    task automatic drive_step();
        int   k, c, m;
        exp_t e;
        if (edges < 1) return;
        k = edges - 1;
        c = k % 128;
        if (c == 126) begin
            check($sformatf("ready_hc127_k%0d", k), 128'(sample_ready), 128'd1);
            m = k / 128 + 1;
            sample_rate_code = 4'b1100;
            if (m == 1 || m == 10 || m == 300) begin
                sample_valid = 1'b0;
                sample_left  = 24'($urandom);
                sample_right = 24'($urandom);
                validity     = 1'b1;
                e.l = 24'd0;
                e.r = 24'd0;
                e.v = 1'b1;
            end else begin
                sample_valid = 1'b1;
                if (m == 4) begin
                    sample_left  = 24'h000001;
                    sample_right = 24'h800000;
                    validity     = 1'b1;
                end else if (m == 5) begin
                    sample_left  = 24'h123456;
                    sample_right = 24'h123456;
                    validity     = 1'b0;
                end else begin
                    sample_left  = 24'($urandom);
                    sample_right = 24'($urandom);
                    validity     = ($urandom_range(0, 7) != 0);
                end
                e.l = sample_left;
                e.r = sample_right;
                e.v = ~validity;
            end
            e.fr = m % 192;
            if (e.fr == 0) model_code = sample_rate_code;
            e.code = model_code;
            exp_q.push_back(e);
            und_q.push_back(!sample_valid);
        end else begin
            if (c == 127) check($sformatf("ready_low_k%0d", k), 128'(sample_ready), 128'd0);
            sample_valid     = 1'($urandom);
            validity         = 1'($urandom);
            sample_left      = 24'($urandom);
            sample_right     = 24'($urandom);
            sample_rate_code = 4'($urandom);
        end
    endtask

    task automatic release_reset();
        exp_t e;
        model_code = 4'd0;
        e.l = 24'd0;
        e.r = 24'd0;
        e.v = 1'b1;
        e.fr = 0;
        e.code = 4'd0;
        exp_q.push_back(e);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n            = 1'b0;
        sample_left      = 24'd0;
        sample_right     = 24'd0;
        sample_valid     = 1'b0;
        validity         = 1'b0;
        sample_rate_code = 4'b1100;
        model_code       = 4'd0;
        repeat (4) begin
            @(negedge clk);
            check("ready_in_reset", 128'(sample_ready), 128'd0);
        end
        release_reset();

        // Two full blocks, then into frame 100 of the third block
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            drive_step();
            if (edges - 1 == 484 * 128 + 59) break;
        end

        rst_n = 1'b0;
        exp_q.delete();
        und_q.delete();
        repeat (3) begin
            @(negedge clk);
            check("ready_in_mid_reset", 128'(sample_ready), 128'd0);
        end
        release_reset();

        for (int i = 0; i < 4 * 128 + 10; i++) begin
            @(negedge clk);
            drive_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spdif_frame_encoder.md
SPDIF_FRAME_ENCODER -- requirements
Module: spdif_frame_encoder

Interface
REQ-001 SHALL have parameter CS_COPY_PERMIT, default 1, value of channel-status bit 2.
REQ-002 SHALL have port clk  input  1  half-cell clock, 128 x fs; one BMC half-cell per cycle.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous to clk, active-low.
REQ-004 SHALL have port sample_left  input  24  left PCM sample, two's complement.
REQ-005 SHALL have port sample_right  input  24  right PCM sample, two's complement.
REQ-006 SHALL have port sample_valid  input  1  sample pair and validity offered.
REQ-007 SHALL have port validity  input  1  1 = audio valid; transmitted V bit = ~validity.
REQ-008 SHALL have port sample_rate_code  input  4  channel-status bits 24-27.
REQ-009 SHALL have port sample_ready  output  1  encoder accepts the offered pair this cycle.
REQ-010 SHALL have port spdif_out  output  1  biphase-mark line output.
REQ-011 SHALL have port block_start  output  1  one-cycle pulse on first half-cell of frame 0.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse when a frame boundary passes with no sample.

Function
REQ-013 SHALL keep a 7-bit half-cell counter hc (0..127, wrap) and an 8-bit frame counter fr (0..191, wrap at 191 when hc wraps).
REQ-014 SHALL map hc[6] to subframe (0 = left/A, 1 = right/B), hc[5:1] to slot 0..31, hc[0] to half-cell within slot.
REQ-015 SHALL send preamble in slots 0-3: B = 11101000 (A, fr = 0), M = 11100010 (A, fr != 0), W = 11100100 (B), each XORed with the spdif_out level of the preceding cycle.
REQ-016 SHALL send slots 4-27 as sample bits 0..23, LSB first.
REQ-017 SHALL send slot 28 = V, slot 29 = U = 0, slot 30 = C = channel-status bit fr, slot 31 = P, even parity over slots 4-30.
REQ-018 SHALL BMC-encode slots 4-31: toggle at hc[0] = 0 of every slot; toggle again at hc[0] = 1 only when the bit is 1.
REQ-019 SHALL use channel status, identical for A and B: bit 2 = CS_COPY_PERMIT, bits 24-27 = sample_rate_code (bit 24 = code LSB), bit 32 = 1, all other bits 0.
REQ-020 SHALL latch sample_rate_code at hc = 127, fr = 191; this value covers the whole following block.
REQ-021 SHALL assert sample_ready combinationally only when hc = 127.
REQ-022 SHALL load sample_left, sample_right and validity into holding registers when sample_ready and sample_valid are both 1; these drive the next frame.
REQ-023 SHALL hold sample_ready for exactly one cycle per 128 when sample_valid = 0 at hc = 127, and SHALL NOT stall.
REQ-024 SHALL on that underrun load zero samples with V = 1 into the holding registers and pulse underrun in the next cycle.
REQ-025 SHALL give latency of 9 cycles: sample bit 0 occupies the cells starting at hc = 8 of the next frame.
REQ-026 SHALL register spdif_out, with no combinational path from any input to spdif_out.
REQ-027 SHALL register block_start and pulse it in the cycle where hc = 0 and fr = 0.

Reset
REQ-028 SHALL, while rst_n = 0 at a clk edge, set hc = 0, fr = 0, spdif_out = 0, block_start = 0, underrun = 0, holding samples = 0, held V = 1, latched rate code = 0.
REQ-029 SHALL abort any frame in progress on reset; the first frame after release SHALL start at hc = 0 with preamble B, zero audio and V = 1.
REQ-030 SHALL hold sample_ready = 0 while rst_n = 0.

Structure
REQ-031 SHALL put constants in shared package spdif_pkg: HALFCELLS_PER_FRAME = 128, FRAMES_PER_BLOCK = 192, PREAMBLE_B/M/W 8-bit patterns, channel-status bit indices 2, 24, 32.
REQ-032 SHALL implement channel status as sub-module spdif_cs_rom (combinational: frame index, rate code, copy-permit -> C bit).

Verification
REQ-033 SHALL cover: reset release, no valid -> first frame preamble B from level 0 = 11101000, V = 1, block_start at cycle 0, underrun pulse after cycle 127.
REQ-034 SHALL cover: left = 24'h000001, right = 24'h800000, valid = 1 -> slot 4 of A carries 1, slot 27 of B carries 1, both P = 1.
REQ-035 SHALL cover: continuous valid pairs over 2 blocks -> block_start every 24576 cycles; C bit 2 = 1, bits 24-27 = code 4'b1100 read back; M preamble on frames 1-191.
REQ-036 SHALL cover: validity = 0 with data 24'h123456 -> data transmitted unchanged, slot 28 = 1.
REQ-037 SHALL cover: drop sample_valid for one frame mid-stream -> that frame all-zero audio, V = 1, one underrun pulse, next frame resumes data.
REQ-038 SHALL cover: rst_n low for 3 cycles at hc = 60 of frame 100 -> spdif_out = 0, then restart with preamble B and fr = 0; a BMC decoder model reports no cell violations throughout.
